// File: rtl/fixed_point_pkg.sv
// Shared signed fixed-point format (Q16.16) plus the divider's sizing constants and FSM states.
package fixed_point;

  localparam int fraction_w = 16;

  typedef logic signed [31:0] fixed_point_t;

  localparam int FP_W         = $bits(fixed_point_t);
  localparam int FP_DIV_STEPS = FP_W + fraction_w;
  localparam int FP_DIV_CNT_W = $clog2(FP_DIV_STEPS + 1);

  typedef enum logic [1:0] {
    FP_DIV_IDLE,
    FP_DIV_DIVIDE,
    FP_DIV_DONE
  } fp_div_state_t;

endpackage

// File: rtl/fixed_point_div.sv
// Sequential signed fixed-point divider: result = (op1 << F) / op2, truncated toward zero,
// one restoring step per clock on magnitudes with sign fix-up on completion.
module fixed_point_div
  import fixed_point::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  fixed_point_t op1,
  input  fixed_point_t op2,
  output logic         out_valid,
  input  logic         out_ready,
  output fixed_point_t result,
  output logic         overflow,
  output logic         div_by_zero
);

  localparam int W = FP_W;
  localparam int F = fraction_w;
  localparam int N = FP_DIV_STEPS;

  localparam logic [N-1:0] Q_NEG_MAX = {{F{1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic [N-1:0] Q_POS_MAX = Q_NEG_MAX - 1'b1;

  fp_div_state_t           state_q;
  logic [FP_DIV_CNT_W-1:0] cnt_q;
  logic [W:0]              rem_q;
  logic [N-1:0]            q_q;
  logic [W-1:0]            div_q;
  logic                    sign_q;
  fixed_point_t            result_q;
  logic                    overflow_q;
  logic                    dbz_q;

  logic [W:0]   rem_sh;
  logic         q_bit;
  logic [W:0]   rem_d;
  logic [N-1:0] q_d;

  // Magnitude as unsigned; the most-negative value maps to 2^(W-1).
  function automatic logic [W-1:0] abs_mag(input fixed_point_t x);
    logic [W-1:0] u;
    u = x;
    return x[W-1] ? (~u + 1'b1) : u;
  endfunction

  function automatic logic fix_overflow(input logic neg, input logic [N-1:0] mag);
    return neg ? (mag > Q_NEG_MAX) : (mag > Q_POS_MAX);
  endfunction

  function automatic fixed_point_t fix_result(input logic neg, input logic [N-1:0] mag);
    logic [W-1:0] lo;
    lo = mag[W-1:0];
    return neg ? fixed_point_t'(~lo + 1'b1) : fixed_point_t'(lo);
  endfunction

  // Restoring step: dividend bits stream out of Q's MSB while quotient bits enter its LSB.
  always_comb begin
    rem_sh = (rem_q << 1) | {{W{1'b0}}, q_q[N-1]};
    q_bit  = (rem_sh >= {1'b0, div_q});
    rem_d  = q_bit ? (rem_sh - {1'b0, div_q}) : rem_sh;
    q_d    = {q_q[N-2:0], q_bit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FP_DIV_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      q_q        <= '0;
      div_q      <= '0;
      sign_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      case (state_q)
        FP_DIV_IDLE: begin
          if (in_valid) begin
            sign_q  <= op1[W-1] ^ op2[W-1];
            div_q   <= abs_mag(op2);
            q_q     <= {abs_mag(op1), {F{1'b0}}};
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= FP_DIV_DIVIDE;
          end
        end
        FP_DIV_DIVIDE: begin
          // A zero divisor is caught on the first cycle after capture.
          if (div_q == '0) begin
            result_q   <= '0;
            overflow_q <= 1'b1;
            dbz_q      <= 1'b1;
            state_q    <= FP_DIV_DONE;
          end else begin
            rem_q <= rem_d;
            q_q   <= q_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == FP_DIV_CNT_W'(N - 1)) begin
              result_q   <= fix_result(sign_q, q_d);
              overflow_q <= fix_overflow(sign_q, q_d);
              dbz_q      <= 1'b0;
              state_q    <= FP_DIV_DONE;
            end
          end
        end
        FP_DIV_DONE: begin
          if (out_ready) state_q <= FP_DIV_IDLE;
        end
        default: state_q <= FP_DIV_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == FP_DIV_IDLE);
  assign out_valid   = (state_q == FP_DIV_DONE);
  assign result      = result_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dbz_q;

endmodule
